// File: rtl/out_collector_pkg.sv
`default_nettype none
// ============================================================================
// Module      : out_collector_pkg
// Description : Shared defaults for the systolic array output path (column
//               count, partial-sum width, per-column buffer depth) and a
//               log2 helper used to size buffer pointers.
// Revision    : 1.0 - initial release
// ============================================================================
package out_collector_pkg;

    localparam int COL_DEF     = 8;
    localparam int PSUM_BW_DEF = 16;
    localparam int DEPTH_DEF   = 8;

    // Ceiling log2, evaluated at elaboration time for pointer widths.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage : out_collector_pkg
`default_nettype wire

// File: rtl/col_fifo.sv
`default_nettype none
// ============================================================================
// Module      : col_fifo
// Description : Single-column circular buffer for the output collector.
//               Pointers carry one extra wrap bit so full and empty are
//               distinguishable without a separate occupancy counter.
// Ports       : clk     - clock, rising edge
//               reset   - synchronous active-high reset
//               wr_i    - write strobe for din_i
//               rd_i    - pop strobe (only asserted when every column has data)
//               din_i   - data in
//               dout_o  - head-of-buffer data (combinational read)
//               full_o  - buffer holds DEPTH entries
//               empty_o - buffer holds no entries
//               drop_o  - this cycle's write is being discarded
// Revision    : 1.0 - initial release
// ============================================================================
module col_fifo
    import out_collector_pkg::*;
#(
    parameter int DW    = PSUM_BW_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_i,
    input  logic          rd_i,
    input  logic [DW-1:0] din_i,
    output logic [DW-1:0] dout_o,
    output logic          full_o,
    output logic          empty_o,
    output logic          drop_o
);

    localparam int AW = clog2(DEPTH);

    logic [AW:0]   wptr_q, wptr_d;
    logic [AW:0]   rptr_q, rptr_d;
    logic [DW-1:0] mem_q [DEPTH];
    logic          w_wr_en;
    logic          w_rd_en;

    assign full_o  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
    assign empty_o = (wptr_q == rptr_q);

    // A full buffer still accepts a write when the same cycle pops, since the
    // slot being written is the one being vacated.
    assign w_wr_en = wr_i && (!full_o || rd_i);
    assign w_rd_en = rd_i && !empty_o;
    assign drop_o  = wr_i && !w_wr_en;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (w_wr_en) begin
            wptr_d = wptr_q + {{AW{1'b0}}, 1'b1};
        end
        if (w_rd_en) begin
            rptr_d = rptr_q + {{AW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage is not reset: stale contents are unreachable while empty.
    always_ff @(posedge clk) begin
        if (w_wr_en && !reset) begin
            mem_q[wptr_q[AW-1:0]] <= din_i;
        end
    end

    assign dout_o = mem_q[rptr_q[AW-1:0]];

endmodule : col_fifo
`default_nettype wire

// File: rtl/out_collector.sv
`default_nettype none
// ============================================================================
// Module      : out_collector
// Description : Deskews the south-edge partial sums of a systolic array.
//               Each column fills its own buffer as results arrive; a row is
//               popped only once every column holds at least one entry.
// Ports       : clk        - clock, rising edge
//               reset      - synchronous active-high reset
//               in_s       - packed column psums, column i at [psum_bw*i +: psum_bw]
//               valid      - per-column write strobe
//               rd         - pop request for one aligned row
//               out        - registered popped row (1-cycle latency)
//               o_valid    - every column non-empty
//               o_ready    - no column full
//               o_overflow - sticky flag, a write was dropped
// Revision    : 1.0 - initial release
// ============================================================================
module out_collector
    import out_collector_pkg::*;
#(
    parameter int col     = COL_DEF,
    parameter int psum_bw = PSUM_BW_DEF,
    parameter int depth   = DEPTH_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [psum_bw*col-1:0] in_s,
    input  logic [col-1:0]         valid,
    input  logic                   rd,
    output logic [psum_bw*col-1:0] out,
    output logic                   o_valid,
    output logic                   o_ready,
    output logic                   o_overflow
);

    logic [col-1:0]         w_empty;
    logic [col-1:0]         w_full;
    logic [col-1:0]         w_drop;
    logic [psum_bw*col-1:0] w_row;
    logic                   w_pop;

    logic [psum_bw*col-1:0] out_q, out_d;
    logic                   ovf_q, ovf_d;

    // Status depends only on pointer state, so no combinational path from
    // rd or valid reaches o_valid / o_ready.
    assign o_valid = &(~w_empty);
    assign o_ready = &(~w_full);
    assign w_pop   = rd && o_valid;

    for (genvar i = 0; i < col; i++) begin : g_col
        col_fifo #(
            .DW    (psum_bw),
            .DEPTH (depth)
        ) u_col_fifo (
            .clk     (clk),
            .reset   (reset),
            .wr_i    (valid[i]),
            .rd_i    (w_pop),
            .din_i   (in_s[psum_bw*i +: psum_bw]),
            .dout_o  (w_row[psum_bw*i +: psum_bw]),
            .full_o  (w_full[i]),
            .empty_o (w_empty[i]),
            .drop_o  (w_drop[i])
        );
    end

    always_comb begin
        out_d = out_q;
        ovf_d = ovf_q | (|w_drop);
        if (w_pop) begin
            out_d = w_row;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            out_q <= out_d;
            ovf_q <= ovf_d;
        end
    end

    assign out        = out_q;
    assign o_overflow = ovf_q;

endmodule : out_collector
`default_nettype wire

// File: tb/tb_out_collector.sv
`default_nettype none
// ============================================================================
// Module      : tb_out_collector
// Description : Directed self-checking bench for out_collector with a
//               per-column queue model and an expected-row scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_out_collector;

    localparam int COL = 8;
    localparam int BW  = 16;
    localparam int DEP = 8;

    logic               clk;
    logic               reset;
    logic [BW*COL-1:0]  in_s;
    logic [COL-1:0]     valid;
    logic               rd;
    logic [BW*COL-1:0]  out;
    logic               o_valid;
    logic               o_ready;
    logic               o_overflow;

    int errors;
    int checks;

    // Reference model state
    logic [BW-1:0]     mq [COL][$];
    logic [BW*COL-1:0] sb [$];
    logic [BW*COL-1:0] held;
    logic              exp_ovf;

    out_collector #(
        .col     (COL),
        .psum_bw (BW),
        .depth   (DEP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_s       (in_s),
        .valid      (valid),
        .rd         (rd),
        .out        (out),
        .o_valid    (o_valid),
        .o_ready    (o_ready),
        .o_overflow (o_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [BW*COL-1:0] obs, input logic [BW*COL-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic model_all_nonempty();
        logic r;
        r = 1'b1;
        for (int i = 0; i < COL; i++) if (mq[i].size() == 0) r = 1'b0;
        return r;
    endfunction

    function automatic logic model_none_full();
        logic r;
        r = 1'b1;
        for (int i = 0; i < COL; i++) if (mq[i].size() >= DEP) r = 1'b0;
        return r;
    endfunction

    // One clock: drive inputs, update the model, then check after the edge.
    task automatic cycle(input logic r, input logic [COL-1:0] v, input logic [BW*COL-1:0] d, input logic p);
        logic              pop;
        logic [BW*COL-1:0] row;
        reset = r;
        valid = v;
        in_s  = d;
        rd    = p;
        pop   = 1'b0;
        if (r) begin
            for (int i = 0; i < COL; i++) mq[i].delete();
            sb.delete();
            held    = '0;
            exp_ovf = 1'b0;
        end else begin
            pop = p && model_all_nonempty();
            if (pop) begin
                row = '0;
                for (int i = 0; i < COL; i++) row[BW*i +: BW] = mq[i].pop_front();
                sb.push_back(row);
            end
            for (int i = 0; i < COL; i++) begin
                if (v[i]) begin
                    if (mq[i].size() < DEP) mq[i].push_back(d[BW*i +: BW]);
                    else exp_ovf = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        if (pop) held = sb.pop_front();
        chk("out", out, held);
        chk("o_valid", {127'd0, o_valid}, {127'd0, model_all_nonempty()});
        chk("o_ready", {127'd0, o_ready}, {127'd0, model_none_full()});
        chk("o_overflow", {127'd0, o_overflow}, {127'd0, exp_ovf});
    endtask

    initial begin
        logic [BW*COL-1:0] d;
        errors  = 0;
        checks  = 0;
        held    = '0;
        exp_ovf = 1'b0;
        reset   = 1'b1;
        valid   = '0;
        in_s    = '0;
        rd      = 1'b0;

        // Reset then idle
        cycle(1'b1, '0, '0, 1'b0);
        cycle(1'b1, '0, '0, 1'b0);
        cycle(1'b0, '0, '0, 1'b0);
        cycle(1'b0, '0, '0, 1'b1);

        // Diagonal skew: column i arrives at step i
        for (int i = 0; i < COL; i++) begin
            d = '0;
            d[BW*i +: BW] = 16'h0010 + BW'(i);
            cycle(1'b0, COL'(1 << i), d, 1'b0);
        end
        chk("diag_valid", {127'd0, o_valid}, {127'd0, 1'b1});
        cycle(1'b0, '0, '0, 1'b1);
        chk("diag_row", out, 128'h0017_0016_0015_0014_0013_0012_0011_0010);
        cycle(1'b0, '0, '0, 1'b0);

        // Overflow on column 0
        for (int k = 1; k <= 9; k++) begin
            d = '0;
            d[BW-1:0] = BW'(k);
            cycle(1'b0, 8'h01, d, 1'b0);
        end
        chk("ovf_ready", {127'd0, o_ready}, {127'd0, 1'b0});
        chk("ovf_flag", {127'd0, o_overflow}, {127'd0, 1'b1});
        for (int k = 1; k <= 8; k++) begin
            d = '0;
            for (int i = 1; i < COL; i++) d[BW*i +: BW] = BW'(16'h0100 * i + k);
            cycle(1'b0, 8'hFE, d, 1'b0);
        end
        for (int k = 1; k <= 8; k++) begin
            cycle(1'b0, '0, '0, 1'b1);
            chk("ovf_col0_seq", {112'd0, out[BW-1:0]}, {112'd0, BW'(k)});
        end
        cycle(1'b1, '0, '0, 1'b0);

        // Column 3 full, simultaneous write and pop
        for (int k = 0; k < 8; k++) begin
            d = '0;
            for (int i = 0; i < COL; i++) d[BW*i +: BW] = BW'(16'h2000 + 16 * k + i);
            cycle(1'b0, 8'hFF, d, 1'b0);
        end
        d = '0;
        d[BW*3 +: BW] = 16'hABCD;
        cycle(1'b0, 8'h08, d, 1'b1);
        chk("c3_no_ovf", {127'd0, o_overflow}, {127'd0, 1'b0});
        for (int k = 1; k <= 8; k++) begin
            d = '0;
            for (int i = 0; i < COL; i++) d[BW*i +: BW] = BW'(16'h3000 + 16 * k + i);
            cycle(1'b0, 8'hF7, d, 1'b1);
        end
        chk("c3_abcd", {112'd0, out[BW*3 +: BW]}, {112'd0, 16'hABCD});
        cycle(1'b1, '0, '0, 1'b0);

        // Pop attempt with column 5 empty
        d = '0;
        for (int i = 0; i < COL; i++) d[BW*i +: BW] = BW'(16'h5000 + i);
        cycle(1'b0, 8'hDF, d, 1'b0);
        cycle(1'b0, '0, '0, 1'b1);
        chk("c5_out_held", out, '0);
        d = '0;
        d[BW*5 +: BW] = 16'h5555;
        cycle(1'b0, 8'h20, d, 1'b0);
        chk("c5_valid", {127'd0, o_valid}, {127'd0, 1'b1});
        cycle(1'b0, '0, '0, 1'b1);

        // Reset mid-operation, then wrap twice
        for (int k = 0; k < 3; k++) begin
            d = '0;
            for (int i = 0; i < COL; i++) d[BW*i +: BW] = BW'(16'h7000 + 16 * k + i);
            cycle(1'b0, 8'hFF, d, 1'b0);
        end
        cycle(1'b1, 8'hFF, d, 1'b1);
        cycle(1'b0, '0, '0, 1'b1);
        chk("rst_out", out, '0);
        chk("rst_valid", {127'd0, o_valid}, {127'd0, 1'b0});
        for (int k = 0; k < 20; k++) begin
            d = '0;
            for (int i = 0; i < COL; i++) d[BW*i +: BW] = BW'($urandom_range(0, 16'hFFFF));
            cycle(1'b0, 8'hFF, d, 1'b0);
            cycle(1'b0, '0, '0, 1'b1);
            chk("wrap_row", out, d);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_out_collector
`default_nettype wire
